// File: rtl/axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI arbiter, one transaction in flight.
// Define ARB_RR_EN for round-robin IFU/LSU arbitration; default is fixed LSU priority.
module axi_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // IFU AR / R
   input  logic [3:0]            m0_arid_i,
   input  logic [ADDR_W-1:0]     m0_araddr_i,
   input  logic [7:0]            m0_arlen_i,
   input  logic [2:0]            m0_arsize_i,
   input  logic [1:0]            m0_arburst_i,
   input  logic                  m0_arvalid_i,
   output logic                  m0_arready_o,
   output logic [3:0]            m0_rid_o,
   output logic [DATA_W-1:0]     m0_rdata_o,
   output logic [1:0]            m0_rresp_o,
   output logic                  m0_rlast_o,
   output logic                  m0_rvalid_o,
   input  logic                  m0_rready_i,
   // LSU AR / R
   input  logic [3:0]            m1_arid_i,
   input  logic [ADDR_W-1:0]     m1_araddr_i,
   input  logic [7:0]            m1_arlen_i,
   input  logic [2:0]            m1_arsize_i,
   input  logic [1:0]            m1_arburst_i,
   input  logic                  m1_arvalid_i,
   output logic                  m1_arready_o,
   output logic [3:0]            m1_rid_o,
   output logic [DATA_W-1:0]     m1_rdata_o,
   output logic [1:0]            m1_rresp_o,
   output logic                  m1_rlast_o,
   output logic                  m1_rvalid_o,
   input  logic                  m1_rready_i,
   // LSU AW / W / B
   input  logic [3:0]            m1_awid_i,
   input  logic [ADDR_W-1:0]     m1_awaddr_i,
   input  logic [7:0]            m1_awlen_i,
   input  logic [2:0]            m1_awsize_i,
   input  logic [1:0]            m1_awburst_i,
   input  logic                  m1_awvalid_i,
   output logic                  m1_awready_o,
   input  logic [3:0]            m1_wid_i,
   input  logic [DATA_W-1:0]     m1_wdata_i,
   input  logic [DATA_W/8-1:0]   m1_wstrb_i,
   input  logic                  m1_wlast_i,
   input  logic                  m1_wvalid_i,
   output logic                  m1_wready_o,
   output logic [3:0]            m1_bid_o,
   output logic [1:0]            m1_bresp_o,
   output logic                  m1_bvalid_o,
   input  logic                  m1_bready_i,
   // Slave side
   output logic [3:0]            s_arid_o,
   output logic [ADDR_W-1:0]     s_araddr_o,
   output logic [7:0]            s_arlen_o,
   output logic [2:0]            s_arsize_o,
   output logic [1:0]            s_arburst_o,
   output logic                  s_arvalid_o,
   input  logic                  s_arready_i,
   output logic [3:0]            s_awid_o,
   output logic [ADDR_W-1:0]     s_awaddr_o,
   output logic [7:0]            s_awlen_o,
   output logic [2:0]            s_awsize_o,
   output logic [1:0]            s_awburst_o,
   output logic                  s_awvalid_o,
   input  logic                  s_awready_i,
   output logic [3:0]            s_wid_o,
   output logic [DATA_W-1:0]     s_wdata_o,
   output logic [DATA_W/8-1:0]   s_wstrb_o,
   output logic                  s_wlast_o,
   output logic                  s_wvalid_o,
   input  logic                  s_wready_i,
   input  logic [3:0]            s_rid_i,
   input  logic [DATA_W-1:0]     s_rdata_i,
   input  logic [1:0]            s_rresp_i,
   input  logic                  s_rlast_i,
   input  logic                  s_rvalid_i,
   output logic                  s_rready_o,
   input  logic [3:0]            s_bid_i,
   input  logic [1:0]            s_bresp_i,
   input  logic                  s_bvalid_i,
   output logic                  s_bready_o
);

   typedef enum logic [3:0] {
      StIdle = 4'b0001,
      StM0Rd = 4'b0010,
      StM1Rd = 4'b0100,
      StM1Wr = 4'b1000
   } state_e;

   state_e r_state;
   logic   r_ar_done;
   logic   r_aw_done;
   logic   r_w_done;
`ifdef ARB_RR_EN
   logic   r_last_grant;  // 1: LSU served most recently
`endif

   logic w_r0, w_r1r, w_r1w;
   logic w_ar_hs, w_aw_hs, w_w_last_hs, w_r_last_hs, w_b_hs, w_wr_done;

   assign w_r0        = m0_arvalid_i;
   assign w_r1r       = m1_arvalid_i;
   assign w_r1w       = m1_awvalid_i | m1_wvalid_i;
   assign w_ar_hs     = s_arvalid_o & s_arready_i;
   assign w_aw_hs     = s_awvalid_o & s_awready_i;
   assign w_w_last_hs = s_wvalid_o & s_wready_i & s_wlast_o;
   assign w_r_last_hs = s_rvalid_i & s_rready_o & s_rlast_i;
   assign w_b_hs      = s_bvalid_i & s_bready_o;
   assign w_wr_done   = r_aw_done & r_w_done;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= StIdle;
         r_ar_done <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
`ifdef ARB_RR_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
`ifdef ARB_RR_EN
               // LSU wins unless the IFU also requests and the LSU was served last
               if ((w_r1r | w_r1w) & (~w_r0 | ~r_last_grant)) begin
                  r_state      <= w_r1r ? StM1Rd : StM1Wr;
                  r_last_grant <= 1'b1;
               end else if (w_r0) begin
                  r_state      <= StM0Rd;
                  r_last_grant <= 1'b0;
               end
`else
               if (w_r1r) begin
                  r_state <= StM1Rd;
               end else if (w_r1w) begin
                  r_state <= StM1Wr;
               end else if (w_r0) begin
                  r_state <= StM0Rd;
               end
`endif
            end
            StM0Rd, StM1Rd: begin
               if (w_ar_hs) begin
                  r_ar_done <= 1'b1;
               end
               if (w_r_last_hs) begin
                  r_state   <= StIdle;
                  r_ar_done <= 1'b0;
               end
            end
            StM1Wr: begin
               if (w_aw_hs) begin
                  r_aw_done <= 1'b1;
               end
               if (w_w_last_hs) begin
                  r_w_done <= 1'b1;
               end
               if (w_b_hs) begin
                  r_state   <= StIdle;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
               end
            end
            default: begin
               r_state   <= StIdle;
               r_ar_done <= 1'b0;
               r_aw_done <= 1'b0;
               r_w_done  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      s_arid_o     = '0;
      s_araddr_o   = '0;
      s_arlen_o    = '0;
      s_arsize_o   = '0;
      s_arburst_o  = '0;
      s_arvalid_o  = 1'b0;
      s_awid_o     = '0;
      s_awaddr_o   = '0;
      s_awlen_o    = '0;
      s_awsize_o   = '0;
      s_awburst_o  = '0;
      s_awvalid_o  = 1'b0;
      s_wid_o      = '0;
      s_wdata_o    = '0;
      s_wstrb_o    = '0;
      s_wlast_o    = 1'b0;
      s_wvalid_o   = 1'b0;
      s_rready_o   = 1'b0;
      s_bready_o   = 1'b0;
      m0_arready_o = 1'b0;
      m0_rid_o     = '0;
      m0_rdata_o   = '0;
      m0_rresp_o   = '0;
      m0_rlast_o   = 1'b0;
      m0_rvalid_o  = 1'b0;
      m1_arready_o = 1'b0;
      m1_rid_o     = '0;
      m1_rdata_o   = '0;
      m1_rresp_o   = '0;
      m1_rlast_o   = 1'b0;
      m1_rvalid_o  = 1'b0;
      m1_awready_o = 1'b0;
      m1_wready_o  = 1'b0;
      m1_bid_o     = '0;
      m1_bresp_o   = '0;
      m1_bvalid_o  = 1'b0;
      unique case (r_state)
         StM0Rd: begin
            s_arid_o     = m0_arid_i;
            s_araddr_o   = m0_araddr_i;
            s_arlen_o    = m0_arlen_i;
            s_arsize_o   = m0_arsize_i;
            s_arburst_o  = m0_arburst_i;
            s_arvalid_o  = m0_arvalid_i & ~r_ar_done;
            m0_arready_o = s_arready_i & ~r_ar_done;
            m0_rid_o     = s_rid_i;
            m0_rdata_o   = s_rdata_i;
            m0_rresp_o   = s_rresp_i;
            m0_rlast_o   = s_rlast_i;
            m0_rvalid_o  = s_rvalid_i;
            s_rready_o   = m0_rready_i;
         end
         StM1Rd: begin
            s_arid_o     = m1_arid_i;
            s_araddr_o   = m1_araddr_i;
            s_arlen_o    = m1_arlen_i;
            s_arsize_o   = m1_arsize_i;
            s_arburst_o  = m1_arburst_i;
            s_arvalid_o  = m1_arvalid_i & ~r_ar_done;
            m1_arready_o = s_arready_i & ~r_ar_done;
            m1_rid_o     = s_rid_i;
            m1_rdata_o   = s_rdata_i;
            m1_rresp_o   = s_rresp_i;
            m1_rlast_o   = s_rlast_i;
            m1_rvalid_o  = s_rvalid_i;
            s_rready_o   = m1_rready_i;
         end
         StM1Wr: begin
            s_awid_o     = m1_awid_i;
            s_awaddr_o   = m1_awaddr_i;
            s_awlen_o    = m1_awlen_i;
            s_awsize_o   = m1_awsize_i;
            s_awburst_o  = m1_awburst_i;
            s_awvalid_o  = m1_awvalid_i & ~r_aw_done;
            m1_awready_o = s_awready_i & ~r_aw_done;
            s_wid_o      = m1_wid_i;
            s_wdata_o    = m1_wdata_i;
            s_wstrb_o    = m1_wstrb_i;
            s_wlast_o    = m1_wlast_i;
            s_wvalid_o   = m1_wvalid_i & ~r_w_done;
            m1_wready_o  = s_wready_i & ~r_w_done;
            // B is only accepted once both address and last data beat have gone out
            m1_bid_o     = s_bid_i;
            m1_bresp_o   = s_bresp_i;
            m1_bvalid_o  = s_bvalid_i & w_wr_done;
            s_bready_o   = m1_bready_i & w_wr_done;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: per-cycle vector table plus write, burst and reset sequences.
module tb_axi_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   // Control input bits
   localparam logic [13:0] InM0Ar   = 14'h0001;
   localparam logic [13:0] InM1Ar   = 14'h0002;
   localparam logic [13:0] InM1Aw   = 14'h0004;
   localparam logic [13:0] InM1W    = 14'h0008;
   localparam logic [13:0] InWLast  = 14'h0010;
   localparam logic [13:0] InSArRdy = 14'h0020;
   localparam logic [13:0] InSAwRdy = 14'h0040;
   localparam logic [13:0] InSWRdy  = 14'h0080;
   localparam logic [13:0] InSRV    = 14'h0100;
   localparam logic [13:0] InSRLast = 14'h0200;
   localparam logic [13:0] InSBV    = 14'h0400;
   localparam logic [13:0] InM0RRdy = 14'h0800;
   localparam logic [13:0] InM1RRdy = 14'h1000;
   localparam logic [13:0] InM1BRdy = 14'h2000;

   // Handshake output bits
   localparam logic [11:0] OSArV    = 12'h001;
   localparam logic [11:0] OSAwV    = 12'h002;
   localparam logic [11:0] OSWV     = 12'h004;
   localparam logic [11:0] OSRRdy   = 12'h008;
   localparam logic [11:0] OSBRdy   = 12'h010;
   localparam logic [11:0] OM0ArRdy = 12'h020;
   localparam logic [11:0] OM1ArRdy = 12'h040;
   localparam logic [11:0] OM1AwRdy = 12'h080;
   localparam logic [11:0] OM1WRdy  = 12'h100;
   localparam logic [11:0] OM0RV    = 12'h200;
   localparam logic [11:0] OM1RV    = 12'h400;
   localparam logic [11:0] OM1BV    = 12'h800;

   localparam int NV = 18;

   typedef struct packed {
      logic [13:0] in;
      logic [31:0] rdata;
      logic [11:0] hs;
      logic [31:0] araddr;
      logic [31:0] m0_rdata;
      logic [31:0] m1_rdata;
   } vec_t;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic [3:0]          m0_arid_i, m1_arid_i, m1_awid_i, m1_wid_i;
   logic [ADDR_W-1:0]   m0_araddr_i, m1_araddr_i, m1_awaddr_i;
   logic [7:0]          m0_arlen_i, m1_arlen_i, m1_awlen_i;
   logic [2:0]          m0_arsize_i, m1_arsize_i, m1_awsize_i;
   logic [1:0]          m0_arburst_i, m1_arburst_i, m1_awburst_i;
   logic                m0_arvalid_i, m1_arvalid_i, m1_awvalid_i, m1_wvalid_i, m1_wlast_i;
   logic                m0_arready_o, m1_arready_o, m1_awready_o, m1_wready_o;
   logic [3:0]          m0_rid_o, m1_rid_o, m1_bid_o;
   logic [DATA_W-1:0]   m0_rdata_o, m1_rdata_o, m1_wdata_i;
   logic [DATA_W/8-1:0] m1_wstrb_i, s_wstrb_o;
   logic [1:0]          m0_rresp_o, m1_rresp_o, m1_bresp_o;
   logic                m0_rlast_o, m1_rlast_o, m0_rvalid_o, m1_rvalid_o, m1_bvalid_o;
   logic                m0_rready_i, m1_rready_i, m1_bready_i;
   logic [3:0]          s_arid_o, s_awid_o, s_wid_o, s_rid_i, s_bid_i;
   logic [ADDR_W-1:0]   s_araddr_o, s_awaddr_o;
   logic [7:0]          s_arlen_o, s_awlen_o;
   logic [2:0]          s_arsize_o, s_awsize_o;
   logic [1:0]          s_arburst_o, s_awburst_o, s_rresp_i, s_bresp_i;
   logic                s_arvalid_o, s_awvalid_o, s_wvalid_o, s_wlast_o;
   logic                s_arready_i, s_awready_i, s_wready_i;
   logic [DATA_W-1:0]   s_wdata_o, s_rdata_i;
   logic                s_rlast_i, s_rvalid_i, s_rready_o, s_bvalid_i, s_bready_o;

   logic [11:0] w_hs;
   logic        w_payload_any;
   int          n_chk;
   int          n_fail;
   int          b_pulses;
   vec_t        vecs [NV];

   axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_arid_i(m0_arid_i), .m0_araddr_i(m0_araddr_i), .m0_arlen_i(m0_arlen_i),
      .m0_arsize_i(m0_arsize_i), .m0_arburst_i(m0_arburst_i), .m0_arvalid_i(m0_arvalid_i),
      .m0_arready_o(m0_arready_o), .m0_rid_o(m0_rid_o), .m0_rdata_o(m0_rdata_o),
      .m0_rresp_o(m0_rresp_o), .m0_rlast_o(m0_rlast_o), .m0_rvalid_o(m0_rvalid_o),
      .m0_rready_i(m0_rready_i),
      .m1_arid_i(m1_arid_i), .m1_araddr_i(m1_araddr_i), .m1_arlen_i(m1_arlen_i),
      .m1_arsize_i(m1_arsize_i), .m1_arburst_i(m1_arburst_i), .m1_arvalid_i(m1_arvalid_i),
      .m1_arready_o(m1_arready_o), .m1_rid_o(m1_rid_o), .m1_rdata_o(m1_rdata_o),
      .m1_rresp_o(m1_rresp_o), .m1_rlast_o(m1_rlast_o), .m1_rvalid_o(m1_rvalid_o),
      .m1_rready_i(m1_rready_i),
      .m1_awid_i(m1_awid_i), .m1_awaddr_i(m1_awaddr_i), .m1_awlen_i(m1_awlen_i),
      .m1_awsize_i(m1_awsize_i), .m1_awburst_i(m1_awburst_i), .m1_awvalid_i(m1_awvalid_i),
      .m1_awready_o(m1_awready_o),
      .m1_wid_i(m1_wid_i), .m1_wdata_i(m1_wdata_i), .m1_wstrb_i(m1_wstrb_i),
      .m1_wlast_i(m1_wlast_i), .m1_wvalid_i(m1_wvalid_i), .m1_wready_o(m1_wready_o),
      .m1_bid_o(m1_bid_o), .m1_bresp_o(m1_bresp_o), .m1_bvalid_o(m1_bvalid_o),
      .m1_bready_i(m1_bready_i),
      .s_arid_o(s_arid_o), .s_araddr_o(s_araddr_o), .s_arlen_o(s_arlen_o),
      .s_arsize_o(s_arsize_o), .s_arburst_o(s_arburst_o), .s_arvalid_o(s_arvalid_o),
      .s_arready_i(s_arready_i),
      .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o),
      .s_awsize_o(s_awsize_o), .s_awburst_o(s_awburst_o), .s_awvalid_o(s_awvalid_o),
      .s_awready_i(s_awready_i),
      .s_wid_o(s_wid_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o), .s_wlast_o(s_wlast_o),
      .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
      .s_rid_i(s_rid_i), .s_rdata_i(s_rdata_i), .s_rresp_i(s_rresp_i), .s_rlast_i(s_rlast_i),
      .s_rvalid_i(s_rvalid_i), .s_rready_o(s_rready_o),
      .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o)
   );

   always #5 clk_i = ~clk_i;

   assign w_hs = {m1_bvalid_o, m1_rvalid_o, m0_rvalid_o, m1_wready_o, m1_awready_o,
                  m1_arready_o, m0_arready_o, s_bready_o, s_rready_o, s_wvalid_o,
                  s_awvalid_o, s_arvalid_o};

   assign w_payload_any = |{s_arid_o, s_araddr_o, s_arlen_o, s_arsize_o, s_arburst_o,
                            s_awid_o, s_awaddr_o, s_awlen_o, s_awsize_o, s_awburst_o,
                            s_wid_o, s_wdata_o, s_wstrb_o, s_wlast_o,
                            m0_rid_o, m0_rdata_o, m0_rresp_o, m0_rlast_o,
                            m1_rid_o, m1_rdata_o, m1_rresp_o, m1_rlast_o,
                            m1_bid_o, m1_bresp_o};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_in(input logic [13:0] in, input logic [31:0] rdata);
      m0_arvalid_i = in[0];
      m1_arvalid_i = in[1];
      m1_awvalid_i = in[2];
      m1_wvalid_i  = in[3];
      m1_wlast_i   = in[4];
      s_arready_i  = in[5];
      s_awready_i  = in[6];
      s_wready_i   = in[7];
      s_rvalid_i   = in[8];
      s_rlast_i    = in[9];
      s_bvalid_i   = in[10];
      m0_rready_i  = in[11];
      m1_rready_i  = in[12];
      m1_bready_i  = in[13];
      s_rdata_i    = rdata;
   endtask

   // One cycle: drive at the falling edge, compare handshakes 1 ns later
   task automatic step(input logic [13:0] in, input logic [31:0] rdata,
                       input logic [11:0] exp_hs, input string name);
      @(negedge clk_i);
      drive_in(in, rdata);
      #1;
      chk(name, 64'(w_hs), 64'(exp_hs));
      if (m1_bvalid_o) b_pulses++;
   endtask

   initial begin
      int  k;
      bit  done;
      logic rr;
      n_chk    = 0;
      n_fail   = 0;
      b_pulses = 0;

      // IFU only, single beat
      vecs[0]  = '{in: InM0Ar | InSArRdy, rdata: 32'h1234_5678, hs: 12'h0,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[1]  = '{in: InM0Ar | InSArRdy | InM0RRdy, rdata: 32'h0,
                   hs: OSArV | OM0ArRdy | OSRRdy,
                   araddr: 32'h3000_0000, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[2]  = '{in: InM0RRdy | InSRV | InSRLast, rdata: 32'hDEAD_BEEF, hs: OSRRdy | OM0RV,
                   araddr: 32'h3000_0000, m0_rdata: 32'hDEAD_BEEF, m1_rdata: 32'h0};
      vecs[3]  = '{in: 14'h0, rdata: 32'h0, hs: 12'h0,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      // Simultaneous IFU/LSU reads: LSU first
      vecs[4]  = '{in: InM0Ar | InM1Ar | InSArRdy, rdata: 32'hCAFE_0000, hs: 12'h0,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[5]  = '{in: InM0Ar | InM1Ar | InSArRdy | InM1RRdy, rdata: 32'h0,
                   hs: OSArV | OM1ArRdy | OSRRdy,
                   araddr: 32'h4000_0010, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[6]  = '{in: InM0Ar | InM1RRdy | InSRV | InSRLast, rdata: 32'h1111_2222,
                   hs: OSRRdy | OM1RV,
                   araddr: 32'h4000_0010, m0_rdata: 32'h0, m1_rdata: 32'h1111_2222};
      vecs[7]  = '{in: InM0Ar, rdata: 32'h0, hs: 12'h0,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[8]  = '{in: InM0Ar | InSArRdy | InM0RRdy, rdata: 32'h0,
                   hs: OSArV | OM0ArRdy | OSRRdy,
                   araddr: 32'h3000_0000, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[9]  = '{in: InM0RRdy | InSRV | InSRLast, rdata: 32'h5555_AAAA, hs: OSRRdy | OM0RV,
                   araddr: 32'h3000_0000, m0_rdata: 32'h5555_AAAA, m1_rdata: 32'h0};
      vecs[10] = '{in: 14'h0, rdata: 32'h0, hs: 12'h0,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      // LSU read and write together: read wins, then the write
      vecs[11] = '{in: InM1Ar | InM1Aw | InM1W | InWLast, rdata: 32'h0, hs: 12'h0,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[12] = '{in: InM1Ar | InM1Aw | InM1W | InWLast | InSArRdy | InSAwRdy | InSWRdy
                       | InM1RRdy, rdata: 32'h0, hs: OSArV | OM1ArRdy | OSRRdy,
                   araddr: 32'h4000_0010, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[13] = '{in: InM1Aw | InM1W | InWLast | InM1RRdy | InSRV | InSRLast,
                   rdata: 32'h0BAD_F00D, hs: OSRRdy | OM1RV,
                   araddr: 32'h4000_0010, m0_rdata: 32'h0, m1_rdata: 32'h0BAD_F00D};
      vecs[14] = '{in: InM1Aw | InM1W | InWLast, rdata: 32'h0, hs: 12'h0,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[15] = '{in: InM1Aw | InM1W | InWLast | InSAwRdy | InSWRdy | InM1BRdy, rdata: 32'h0,
                   hs: OSAwV | OSWV | OM1AwRdy | OM1WRdy,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[16] = '{in: InM1BRdy | InSBV, rdata: 32'h0, hs: OSBRdy | OM1BV,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};
      vecs[17] = '{in: 14'h0, rdata: 32'h0, hs: 12'h0,
                   araddr: 32'h0, m0_rdata: 32'h0, m1_rdata: 32'h0};

      m0_arid_i    = 4'h1;  m0_araddr_i  = 32'h3000_0000; m0_arlen_i  = 8'd0;
      m0_arsize_i  = 3'd2;  m0_arburst_i = 2'd1;
      m1_arid_i    = 4'h2;  m1_araddr_i  = 32'h4000_0010; m1_arlen_i  = 8'd0;
      m1_arsize_i  = 3'd2;  m1_arburst_i = 2'd1;
      m1_awid_i    = 4'h7;  m1_awaddr_i  = 32'h4000_0020; m1_awlen_i  = 8'd0;
      m1_awsize_i  = 3'd2;  m1_awburst_i = 2'd1;
      m1_wid_i     = 4'h7;  m1_wdata_i   = 32'h00AB_0000; m1_wstrb_i  = 4'b0100;
      s_rid_i      = 4'h3;  s_rresp_i    = 2'b10;
      s_bid_i      = 4'h6;  s_bresp_i    = 2'b01;

      // Reset with requests and slave responses active: nothing may leak through
      rst_i = 1'b1;
      drive_in(InM0Ar | InM1Aw | InM1W | InWLast | InSArRdy | InSRV | InSRLast | InSBV
               | InM0RRdy | InM1BRdy, 32'hFFFF_FFFF);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset_handshakes", 64'(w_hs), 64'h0);
      chk("reset_payload", 64'(w_payload_any), 64'h0);
      rst_i = 1'b0;
      drive_in(14'h0, 32'h0);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk_i);
         drive_in(vecs[i].in, vecs[i].rdata);
         #1;
         chk($sformatf("vec%0d_hs", i), 64'(w_hs), 64'(vecs[i].hs));
         chk($sformatf("vec%0d_araddr", i), 64'(s_araddr_o), 64'(vecs[i].araddr));
         chk($sformatf("vec%0d_m0_rdata", i), 64'(m0_rdata_o), 64'(vecs[i].m0_rdata));
         chk($sformatf("vec%0d_m1_rdata", i), 64'(m1_rdata_o), 64'(vecs[i].m1_rdata));
      end

      // LSU write: wready two cycles ahead of awready, slave raises bvalid early
      b_pulses = 0;
      step(InM1Aw | InM1W | InWLast | InSWRdy | InM1BRdy, 32'h0, 12'h0, "wr_idle");
      step(InM1Aw | InM1W | InWLast | InSWRdy | InM1BRdy, 32'h0, OSAwV | OSWV | OM1WRdy,
           "wr_w_hs");
      chk("wr_wdata", 64'(s_wdata_o), 64'h00AB_0000);
      chk("wr_wstrb", 64'(s_wstrb_o), 64'h4);
      chk("wr_awaddr", 64'(s_awaddr_o), 64'h4000_0020);
      step(InM1Aw | InM1W | InWLast | InSWRdy | InM1BRdy | InSBV, 32'h0, OSAwV,
           "wr_w_masked");
      step(InM1Aw | InM1W | InWLast | InSWRdy | InSAwRdy | InM1BRdy | InSBV, 32'h0,
           OSAwV | OM1AwRdy, "wr_aw_hs");
      step(InSAwRdy | InSWRdy | InM1BRdy | InSBV, 32'h0, OSBRdy | OM1BV, "wr_b_hs");
      chk("wr_bid", 64'(m1_bid_o), 64'h6);
      chk("wr_bresp", 64'(m1_bresp_o), 64'h1);
      step(InSAwRdy | InSWRdy | InM1BRdy | InSBV, 32'h0, 12'h0, "wr_back_idle");
      chk("wr_bvalid_pulses", 64'(b_pulses), 64'd1);

      // IFU burst of four beats, rready toggling, next AR already pending
      m0_arlen_i  = 8'd3;
      m0_araddr_i = 32'h3000_0100;
      step(InM0Ar | InSArRdy, 32'h0, 12'h0, "burst_idle");
      step(InM0Ar | InSArRdy, 32'h0, OSArV | OM0ArRdy, "burst_ar_hs");
      chk("burst_arlen", 64'(s_arlen_o), 64'd3);
      k    = 0;
      done = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
         rr = c[0];
         step(InM0Ar | InSArRdy | InSRV | ((k == 3) ? InSRLast : 14'h0)
              | (rr ? InM0RRdy : 14'h0), 32'hB000_0000 + 32'(k),
              OM0RV | (rr ? OSRRdy : 12'h0), "burst_beat_hs");
         if (m0_rvalid_o && m0_rready_i) begin
            chk($sformatf("burst_beat%0d_data", k), 64'(m0_rdata_o),
                64'(32'hB000_0000 + 32'(k)));
            if (k == 0) begin
               chk("burst_rid", 64'(m0_rid_o), 64'h3);
               chk("burst_rresp", 64'(m0_rresp_o), 64'h2);
            end
            if (m0_rlast_o) done = 1'b1;
            k++;
         end
      end
      chk("burst_beat_count", 64'(k), 64'd4);
      step(InM0Ar | InSArRdy, 32'h0, 12'h0, "burst_released");
      step(InM0Ar | InSArRdy, 32'h0, OSArV | OM0ArRdy, "burst_next_ar");
      step(InM0RRdy | InSRV | InSRLast, 32'h0000_C0DE, OSRRdy | OM0RV, "burst_next_r");
      m0_arlen_i = 8'd0;

      // Reset in the middle of a write after the AW handshake
      step(InM1Aw | InM1W | InWLast | InSAwRdy, 32'h0, 12'h0, "rst_idle");
      step(InM1Aw | InM1W | InWLast | InSAwRdy, 32'h0, OSAwV | OSWV | OM1AwRdy, "rst_aw_hs");
      step(InM1Aw | InM1W | InWLast | InSAwRdy, 32'h0, OSWV, "rst_aw_masked");
      rst_i = 1'b1;
      step(InM1Aw | InM1W | InWLast | InSAwRdy | InSWRdy | InM1BRdy | InSBV, 32'h0, 12'h0,
           "rst_outputs_zero");
      rst_i = 1'b0;
      step(InM1Aw | InM1W | InWLast | InSAwRdy | InSWRdy | InM1BRdy, 32'h0,
           OSAwV | OSWV | OM1AwRdy | OM1WRdy, "rst_fresh_aw_w");
      step(InM1BRdy | InSBV, 32'h0, OSBRdy | OM1BV, "rst_fresh_b");
      step(14'h0, 32'h0, 12'h0, "rst_final_idle");
      chk("final_payload", 64'(w_payload_any), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
